// File: rtl/key_sel_debounce.sv
// key_sel_debounce
//   Debounces one mechanical push-button. Each accepted press toggles the
//   registered select line driving the downstream 2:1 mux, and emits a
//   one-cycle press strobe. Each accepted release emits a one-cycle release
//   strobe. A debounced level is also provided.
//
// Parameters
//   CNT_MAX    : consecutive stable samples needed to accept a level change (>= 2)
//   KEY_ACTIVE : raw key_in level meaning "pressed" (0 = active-low button)
//
// Ports
//   clk           in  : system clock, rising edge
//   rst           in  : asynchronous active-high reset
//   key_in        in  : raw, bouncing button level
//   sel           out : select to downstream mux, toggles per accepted press
//   press_pulse   out : one-cycle strobe on accepted press
//   release_pulse out : one-cycle strobe on accepted release
//   key_state     out : debounced level, 1 = pressed
//
// Configuration macro
//   KEY_SYNC_EN : when defined, key_in passes through a 2-flop synchroniser
//                 (reset to the released level), adding 2 cycles of latency.
//                 Leave undefined only for simulation.

module key_sel_debounce #(
  parameter int unsigned CNT_MAX    = 1000000,
  parameter logic        KEY_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic sel,
  output logic press_pulse,
  output logic release_pulse,
  output logic key_state
);

  localparam int unsigned   CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_F = 2'd1,
    DOWN    = 2'd2,
    REL_F   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          ks_q, ks_d;
  logic          k_s;

`ifdef KEY_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{~KEY_ACTIVE}};
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign k_s = (sync_q[1] == KEY_ACTIVE);
`else
  assign k_s = (key_in == KEY_ACTIVE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      ks_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      ks_q    <= ks_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    ks_d    = ks_q;
    case (state_q)
      IDLE: begin
        if (k_s) begin
          state_d = PRESS_F;
          cnt_d   = '0;
        end
      end
      PRESS_F: begin
        if (!k_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
          sel_d   = ~sel_q;
          ks_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (!k_s) begin
          state_d = REL_F;
          cnt_d   = '0;
        end
      end
      REL_F: begin
        if (k_s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
          ks_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Unreachable with a 2-bit encoding; kept as a recovery path.
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = 1'b0;
        ks_d    = 1'b0;
      end
    endcase
  end

  assign sel           = sel_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign key_state     = ks_q;

endmodule

// File: tb/tb_key_sel_debounce.sv
// Directed bench for key_sel_debounce with CNT_MAX = 4, KEY_ACTIVE = 0.
// Observed vector is {sel, press_pulse, release_pulse, key_state}.
module tb_key_sel_debounce;

`ifdef KEY_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst;
  logic key_in;
  logic sel, press_pulse, release_pulse, key_state;

  int n_checks = 0;
  int n_fail   = 0;

  key_sel_debounce #(
    .CNT_MAX   (4),
    .KEY_ACTIVE(1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .sel          (sel),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .key_state    (key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] expv);
    logic [3:0] obs;
    obs = {sel, press_pulse, release_pulse, key_state};
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed {sel,press,rel,ks}=%b expected %b", tag, obs, expv);
    end
  endtask

  // Hold key pressed for 'hold' edges; pulse expected after edge index 4+LAT.
  task automatic run_press(input string tag, input logic s_new, input int hold);
    key_in = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i < 4 + LAT)       check(tag, {~s_new, 3'b000});
      else if (i == 4 + LAT) check(tag, {s_new, 3'b101});
      else                   check(tag, {s_new, 3'b001});
    end
  endtask

  task automatic run_release(input string tag, input logic s, input int hold);
    key_in = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i < 4 + LAT)       check(tag, {s, 3'b001});
      else if (i == 4 + LAT) check(tag, {s, 3'b010});
      else                   check(tag, {s, 3'b000});
    end
  endtask

  initial begin
    logic [12:0] bounce;
    rst    = 1'b0;
    key_in = 1'b1;

    // Asynchronous reset asserted mid-cycle
    #12 rst = 1'b1;
    #1 check("reset_immediate", 4'b0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("reset_hold", 4'b0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("idle_after_reset", 4'b0000);
    end

    run_press("clean_press", 1'b1, 12);
    run_release("release1", 1'b1, 8);

    // Bounce: pattern applied MSB first; pulse after final five-zero run.
    bounce = 13'b0001000100000;
    for (int i = 0; i < 13 + LAT + 2; i++) begin
      key_in = (i < 13) ? bounce[12 - i] : 1'b0;
      @(posedge clk); #1;
      if (i < 12 + LAT)       check("bounce", 4'b1000);
      else if (i == 12 + LAT) check("bounce_pulse", 4'b0101);
      else                    check("bounce_after", 4'b0001);
    end

    run_release("release2", 1'b0, 8);
    run_press("repress", 1'b1, 8);
    run_release("release3", 1'b1, 8);

    // Reset in the middle of the press filter
    key_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midfilter_pre", 4'b1000);
    end
    rst = 1'b1;
    #1 check("midfilter_reset", 4'b0000);
    #2 rst = 1'b0;
    run_press("refilter", 1'b1, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_sel_debounce.md
# key_sel_debounce

Debounces a single mechanical push-button and turns each accepted press into a toggle of a registered select line. It sits directly upstream of the 2:1 `mux1` stage: `sel` drives the mux `sel` input, so each clean key press swaps which mux data input reaches `out`. It also emits one-cycle press/release pulses and a debounced level for other consumers.

## Interface
- `CNT_MAX`, default 1000000: consecutive stable samples required to accept a level change (20 ms at 50 MHz). Legal range ≥ 2.
- `KEY_ACTIVE`, default 0: raw `key_in` level that means "pressed" (0 = active-low button).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_in`  in  1  raw button level, asynchronous and bouncing.
- `sel`  out  1  registered select to the downstream mux; toggles once per accepted press.
- `press_pulse`  out  1  one-cycle registered strobe on each accepted press.
- `release_pulse`  out  1  one-cycle registered strobe on each accepted release.
- `key_state`  out  1  debounced level, 1 = pressed.

## Operation
- Sampled key `k_s`: `key_in` normalised so 1 = pressed (`key_in == KEY_ACTIVE`), after the optional synchroniser (see Configuration).
- Counter `cnt`, width `$clog2(CNT_MAX)`, unsigned. It never exceeds `CNT_MAX-1` and never wraps.
- FSM, 4 states:
  - **IDLE**: released and stable. If `k_s == 1`, go to PRESS_F with `cnt = 0`.
  - **PRESS_F**: pressed-filter.
    - If `k_s == 0`, go back to IDLE with `cnt = 0`; no outputs change.
    - Otherwise, if `cnt == CNT_MAX-1`, go to DOWN with `cnt = 0`, `press_pulse = 1`, `sel = ~sel`, `key_state = 1`.
    - Otherwise `cnt + 1`.
  - **DOWN**: pressed and stable. If `k_s == 0`, go to REL_F with `cnt = 0`.
  - **REL_F**: release-filter, mirror of PRESS_F.
    - If `k_s == 1`, go back to DOWN with `cnt = 0`.
    - Otherwise, if `cnt == CNT_MAX-1`, go to IDLE with `cnt = 0`, `release_pulse = 1`, `key_state = 0`.
    - Otherwise `cnt + 1`.
- `sel` changes only on accepted presses. Releases never change it.
- Pulses are 1 for exactly one cycle. A pulse can never be back-to-back with another pulse: the minimum spacing is CNT_MAX+1 cycles.
- Undefined state encodings return to IDLE on the next edge with all outputs cleared.

## Timing
- Reset (async assert, takes effect immediately):
  - FSM = IDLE, `cnt = 0`.
  - `sel = 0`, `press_pulse = 0`, `release_pulse = 0`, `key_state = 0`.
  - Synchroniser flops are loaded with the released level `~KEY_ACTIVE`.
- Release of `rst`: the first active edge after deassertion evaluates normally.
- Reset mid-filter (PRESS_F or REL_F): the filter is aborted, no pulse is emitted, and `sel` returns to 0.
- Press latency: let E0 be the edge at which the FSM first sees `k_s = 1` in IDLE.
  - If `k_s` stays 1 through edges E1..E_CNT_MAX, then `press_pulse`, the `sel` toggle and `key_state` rise all appear on the outputs after E_CNT_MAX.
  - That is CNT_MAX+1 edges after the first pressed sample.
- Release latency is identical, measured from the first edge seeing `k_s = 0` in DOWN.
- Any single opposite-level sample during filtering restarts the full CNT_MAX+1 window.
- Synchroniser latency from `key_in` to `k_s`: 0 cycles without the macro, 2 cycles with it.

## Configuration
- Macro: `KEY_SYNC_EN`.
- Defined:
  - `key_in` passes through a 2-flop synchroniser (reset to `~KEY_ACTIVE`) before normalisation.
  - All latencies grow by 2 cycles.
  - Required for real pins.
- Undefined:
  - `key_in` feeds the FSM combinationally; intended for simulation only.
  - All other behaviour is unchanged.

## Test plan
All scenarios use `CNT_MAX = 4`, `KEY_ACTIVE = 0`, macro undefined unless stated.
- **Reset**: assert `rst` mid-cycle with `key_in = 1` -> `sel`, `press_pulse`, `release_pulse`, `key_state` all 0 immediately and stay 0 for 10 cycles with `key_in = 1`.
- **Clean press**: drive `key_in = 0` and hold 12 cycles -> `press_pulse = 1` for exactly one cycle, after the 5th edge seeing 0; `sel` 0->1 and `key_state` 0->1 in the same cycle; no further pulses.
- **Bounce**: `key_in` pattern 0,0,0,1,0,0,0,1,0,0,0,0,0 -> no pulse during the bouncing, then exactly one `press_pulse` at the end of the final five-zero run; `sel = 1`.
- **Release and re-press**:
  - From DOWN, drive `key_in = 1` for 8 cycles -> one `release_pulse` after the 5th edge; `key_state = 0`; `sel` stays 1.
  - A second clean press -> `sel` 1->0.
- **Reset mid-filter**: `key_in = 0` for 3 cycles (`cnt = 2`), then pulse `rst` -> no `press_pulse` ever emitted for that press; `sel = 0`.
  - If `key_in` stays 0 after reset release, the press is re-filtered from scratch: pulse after 5 more edges.
- **`KEY_SYNC_EN` defined**: repeat the clean-press scenario -> `press_pulse` occurs exactly 2 cycles later than in the undefined build.
